// File: rtl/elev_scan_if.sv
// Button, request-lamp and car-status bundle between the hall/car panels and the scheduler.
interface elev_scan_if;
   logic [7:1] btup;
   logic [8:2] btdn;
   logic [8:1] in_bt_floor;
   logic       bt_door_open;
   logic       bt_door_close;
   logic [8:1] floor;
   logic [7:1] reg_btup;
   logic [8:2] reg_btdn;
   logic [8:1] reg_in_bt_floor;
   logic       led_state_up;
   logic       led_state_dn;
   logic       door_open;

   modport master (
      output btup, btdn, in_bt_floor, bt_door_open, bt_door_close,
      input  floor, reg_btup, reg_btdn, reg_in_bt_floor, led_state_up, led_state_dn, door_open
   );

   modport slave (
      input  btup, btdn, in_bt_floor, bt_door_open, bt_door_close,
      output floor, reg_btup, reg_btdn, reg_in_bt_floor, led_state_up, led_state_dn, door_open
   );
endinterface

// File: rtl/elev_scan_scheduler.sv
// Eight-floor SCAN elevator scheduler: latches hall/car calls, sweeps in one direction
// while requests remain ahead, and runs a holdable door timer at each stop.
module elev_scan_scheduler #(
   parameter int unsigned TRAVEL_CYC = 4,
   parameter int unsigned DOOR_CYC   = 6
) (
   input  logic       clk,
   input  logic       rst,
   elev_scan_if.slave bus
);

   localparam int unsigned TW = $clog2(TRAVEL_CYC + 1);
   localparam int unsigned DW = $clog2(DOOR_CYC + 1);

   typedef enum logic [1:0] {StIdle, StMoveUp, StMoveDn, StDoor} state_e;
   typedef enum logic [1:0] {DirNone, DirUp, DirDn} dir_e;

   state_e         state_q, state_d;
   dir_e           dir_q, dir_d;
   logic [8:1]     floor_q, floor_d;
   logic [TW-1:0]  tcnt_q, tcnt_d;
   logic [DW-1:0]  dtmr_q, dtmr_d;
   logic           svc_up_q, svc_up_d;
   logic [7:1]     reg_btup_q, reg_btup_d;
   logic [8:2]     reg_btdn_q, reg_btdn_d;
   logic [8:1]     reg_in_q, reg_in_d;
   logic           led_up_q, led_dn_q, door_open_q;

   logic [8:1]     up_v, dn_v, pend;
   logic [8:1]     door_here, clr_in;
   logic [7:1]     clr_up;
   logic [8:2]     clr_dn;

   logic           go_up, above, below, here, hall_up_here;
   logic [8:1]     nf;
   logic           ahead_nf, hall_nf, in_nf, end_nf, stop_nf;
   logic           ahead_svc, behind_svc, expire;

   function automatic logic [8:1] below_mask(input logic [8:1] f);
      return f - 8'd1;
   endfunction

   function automatic logic [8:1] above_mask(input logic [8:1] f);
      return ~(f | (f - 8'd1));
   endfunction

   // Hall vectors widened to the full floor range so all three share one index space.
   assign up_v = {1'b0, reg_btup_q};
   assign dn_v = {reg_btdn_q, 1'b0};
   assign pend = up_v | dn_v | reg_in_q;

   assign door_here = (state_q == StDoor) ? floor_q : 8'b0;
   assign clr_in    = door_here;
   assign clr_up    = svc_up_q ? door_here[7:1] : 7'b0;
   assign clr_dn    = svc_up_q ? 7'b0 : door_here[8:2];

   // Clear wins over a same-cycle press on the same bit.
   assign reg_btup_d = (reg_btup_q | bus.btup) & ~clr_up;
   assign reg_btdn_d = (reg_btdn_q | bus.btdn) & ~clr_dn;
   assign reg_in_d   = (reg_in_q | bus.in_bt_floor) & ~clr_in;

   always_comb begin
      state_d  = state_q;
      dir_d    = dir_q;
      floor_d  = floor_q;
      tcnt_d   = tcnt_q;
      dtmr_d   = dtmr_q;
      svc_up_d = svc_up_q;

      above        = |(pend & above_mask(floor_q));
      below        = |(pend & below_mask(floor_q));
      here         = |(pend & floor_q);
      hall_up_here = |(up_v & floor_q);

      go_up = (state_q == StMoveUp);
      if (go_up) begin
         nf       = floor_q[8] ? floor_q : (floor_q << 1);
         ahead_nf = |(pend & above_mask(nf));
         hall_nf  = |(up_v & nf);
         end_nf   = nf[8];
      end else begin
         nf       = floor_q[1] ? floor_q : (floor_q >> 1);
         ahead_nf = |(pend & below_mask(nf));
         hall_nf  = |(dn_v & nf);
         end_nf   = nf[1];
      end
      in_nf   = |(reg_in_q & nf);
      stop_nf = in_nf | hall_nf | ~ahead_nf | end_nf;

      ahead_svc  = svc_up_q ? above : below;
      behind_svc = svc_up_q ? below : above;
      // Open beats close; close cuts the remaining dwell short.
      expire     = ~bus.bt_door_open & (bus.bt_door_close | (dtmr_q <= DW'(1)));

      case (state_q)
         StIdle: begin
            if (here) begin
               state_d  = StDoor;
               dtmr_d   = DW'(DOOR_CYC);
               svc_up_d = hall_up_here;
            end else if (above) begin
               state_d = StMoveUp;
               dir_d   = DirUp;
               tcnt_d  = '0;
            end else if (below) begin
               state_d = StMoveDn;
               dir_d   = DirDn;
               tcnt_d  = '0;
            end
         end

         StMoveUp, StMoveDn: begin
            if (tcnt_q == TW'(TRAVEL_CYC - 1)) begin
               tcnt_d  = '0;
               floor_d = nf;
               if (stop_nf) begin
                  state_d  = StDoor;
                  dtmr_d   = DW'(DOOR_CYC);
                  svc_up_d = (ahead_nf | hall_nf) ? go_up : ~go_up;
               end
            end else begin
               tcnt_d = tcnt_q + TW'(1);
            end
         end

         StDoor: begin
            if (expire) begin
               if (ahead_svc) begin
                  state_d = svc_up_q ? StMoveUp : StMoveDn;
                  dir_d   = svc_up_q ? DirUp : DirDn;
                  tcnt_d  = '0;
               end else if (behind_svc) begin
                  state_d = svc_up_q ? StMoveDn : StMoveUp;
                  dir_d   = svc_up_q ? DirDn : DirUp;
                  tcnt_d  = '0;
               end else if (here) begin
                  dtmr_d   = DW'(DOOR_CYC);
                  svc_up_d = hall_up_here;
               end else begin
                  state_d = StIdle;
                  dir_d   = DirNone;
               end
            end else if (bus.bt_door_open) begin
               dtmr_d = DW'(DOOR_CYC);
            end else begin
               dtmr_d = dtmr_q - DW'(1);
            end
         end

         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         dir_q       <= DirNone;
         floor_q     <= 8'b0000_0001;
         tcnt_q      <= '0;
         dtmr_q      <= '0;
         svc_up_q    <= 1'b0;
         reg_btup_q  <= '0;
         reg_btdn_q  <= '0;
         reg_in_q    <= '0;
         led_up_q    <= 1'b0;
         led_dn_q    <= 1'b0;
         door_open_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         dir_q       <= dir_d;
         floor_q     <= floor_d;
         tcnt_q      <= tcnt_d;
         dtmr_q      <= dtmr_d;
         svc_up_q    <= svc_up_d;
         reg_btup_q  <= reg_btup_d;
         reg_btdn_q  <= reg_btdn_d;
         reg_in_q    <= reg_in_d;
         led_up_q    <= (state_d == StMoveUp);
         led_dn_q    <= (state_d == StMoveDn);
         door_open_q <= (state_d == StDoor);
      end
   end

   assign bus.floor           = floor_q;
   assign bus.reg_btup        = reg_btup_q;
   assign bus.reg_btdn        = reg_btdn_q;
   assign bus.reg_in_bt_floor = reg_in_q;
   assign bus.led_state_up    = led_up_q;
   assign bus.led_state_dn    = led_dn_q;
   assign bus.door_open       = door_open_q;

endmodule

// File: doc/elev_scan_scheduler.md
ELEV_SCAN_SCHEDULER -- requirements
Module: elev_scan_scheduler

Interface
REQ-001 Parameters SHALL be: TRAVEL_CYC, 4, clock cycles per one-floor move; DOOR_CYC, 6, clock cycles the door stays open.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 btup  input  [7:1]  hall up-call buttons, level or one-cycle pulse.
REQ-005 btdn  input  [8:2]  hall down-call buttons, level or one-cycle pulse.
REQ-006 in_bt_floor  input  [8:1]  car-panel floor buttons.
REQ-007 bt_door_open / bt_door_close  input  1 each  door hold / door close buttons.
REQ-008 floor  output  [8:1]  one-hot current car floor.
REQ-009 reg_btup[7:1], reg_btdn[8:2], reg_in_bt_floor[8:1]  output  latched pending requests.
REQ-010 led_state_up / led_state_dn  output  1 each  high while in MOVE_UP / MOVE_DN respectively.
REQ-011 door_open  output  1  high exactly while in state DOOR.

Function
REQ-012 Request latching SHALL be: reg <= (reg | button) & ~clear, registered; clear SHALL win over a simultaneous press on the same bit.
REQ-013 FSM states SHALL be IDLE, MOVE_UP, MOVE_DN, DOOR; a direction register dir holds UP, DN or NONE.
REQ-014 "Above" = any pending bit (any of the three registers) for a floor higher than current; "below" likewise lower; "here" = any pending bit at the current floor.
REQ-015 IDLE: here -> DOOR; else above -> MOVE_UP, dir=UP; else below -> MOVE_DN, dir=DN; above and below together -> up wins; none -> stay.
REQ-016 MOVE_*: a travel counter SHALL count TRAVEL_CYC cycles; on terminal count floor shifts one position (left for up, right for down) and the counter reloads.
REQ-017 On each arrival the car SHALL stop (-> DOOR) if reg_in_bt_floor[f], or the hall call in dir at f, or no request ahead in dir; otherwise it SHALL continue without a cycle gap.
REQ-018 floor SHALL never move above floor 8 or below floor 1; reaching 8 (up) or 1 (down) always stops.
REQ-019 On DOOR entry the service direction SHALL be dir if requests ahead or the dir hall call at f are pending, else the opposite direction (IDLE entry: up if reg_btup[f], else down).
REQ-020 While in DOOR, reg_in_bt_floor[f] and the hall call of the service direction at f SHALL be cleared every cycle; the other hall call at f stays pending.
REQ-021 DOOR timer SHALL load DOOR_CYC on entry; bt_door_open reloads it; bt_door_close forces expiry next cycle; both asserted together -> open wins.
REQ-022 On DOOR expiry: requests ahead in service direction -> MOVE in that direction; else requests behind -> MOVE opposite; else here -> DOOR again; else IDLE with dir=NONE.
REQ-023 A press for the current floor during MOVE_* (car between floors) SHALL be treated as a normal request, not a stop.
REQ-024 Outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-025 While rst=1, immediately and independent of clk: floor=8'b0000_0001, state IDLE, dir NONE, all reg_* =0, counters 0, door_open=0, led_state_up=led_state_dn=0.
REQ-026 rst asserted mid-move or mid-door SHALL abort the operation and discard every pending request; first action after release follows REQ-015.

Verification
REQ-027 Reset, btup[5] one-cycle pulse -> reg_btup[5]=1 next cycle, led_state_up=1, floor=5 after 16 cycles, door_open=1 for 6 cycles, reg_btup[5]=0, then IDLE.
REQ-028 Car moving up from 1, btdn[3] and in_bt_floor[6] pressed before floor 2 -> no stop at 3, stop at 6, then MOVE_DN to 3, reg_btdn[3] cleared there.
REQ-029 In DOOR, bt_door_open held 10 cycles -> door_open stays 1 until 6 cycles after release; bt_door_close pulse -> door_open falls next cycle; both together -> stays open.
REQ-030 IDLE at floor 4, btdn[2] and btup[7] same cycle -> MOVE_UP first, serve 7, then MOVE_DN to 2.
REQ-031 rst pulsed during MOVE_DN at floor 6 -> floor=1, all reg_*=0 without waiting for clk.
REQ-032 IDLE at floor 1, in_bt_floor[1] and btup[1] -> DOOR next cycle, both cleared, no movement.
